// File: rtl/hilo_md_ctrl.sv
// HI/LO owner and multiply/divide sequencer: 2-stage multiplier,
// restoring divider, MTHI/MTLO writes, squash handling.
module hilo_md_ctrl #(
    parameter int WIDTH     = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EX_MDValid,
    input  logic [2:0]       EX_MDOp,
    input  logic [WIDTH-1:0] EX_A,
    input  logic [WIDTH-1:0] EX_B,
    input  logic             EX_Adv,
    input  logic             MD_Cancel,
    output logic             isbusy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             MD_Done
);

    localparam int H  = WIDTH / 2;
    localparam int CW = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV_ITERS - 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL0,
        S_MUL1,
        S_DIV,
        S_FIX
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH:0]       r_ma;
    logic [WIDTH:0]       r_mb;
    logic [2*WIDTH-1:0]   r_pl;
    logic [2*WIDTH-1:0]   r_ph;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_dvs;
    logic                 r_sq;
    logic                 r_sr;
    logic [CW-1:0]        r_cnt;

    logic                 w_take;
    logic                 w_op_mul;
    logic                 w_op_div;
    logic                 w_sgn_m;
    logic                 w_sgn_d;
    logic                 w_bz;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [2*WIDTH-1:0]   w_ma_x;
    logic [2*WIDTH-1:0]   w_bl_x;
    logic [2*WIDTH-1:0]   w_bh_x;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH:0]       w_up;
    logic [WIDTH:0]       w_diff;
    logic                 w_ge;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    assign w_take   = EX_MDValid & EX_Adv & ~MD_Cancel & (r_state == S_IDLE);
    assign w_op_mul = (EX_MDOp == OP_MULT) | (EX_MDOp == OP_MULTU);
    assign w_op_div = (EX_MDOp == OP_DIV) | (EX_MDOp == OP_DIVU);
    assign w_sgn_m  = (EX_MDOp == OP_MULT);
    assign w_sgn_d  = (EX_MDOp == OP_DIV);
    assign w_bz     = ~|EX_B;

    // Divide by zero keeps the raw dividend so the remainder is the original A.
    assign w_a_neg = w_sgn_d & EX_A[WIDTH-1] & ~w_bz;
    assign w_b_neg = w_sgn_d & EX_B[WIDTH-1];
    assign w_a_mag = w_a_neg ? -EX_A : EX_A;
    assign w_b_mag = w_b_neg ? -EX_B : EX_B;

    // Product split over the multiplier: low half unsigned, high half signed.
    assign w_ma_x = {{(WIDTH-1){r_ma[WIDTH]}}, r_ma};
    assign w_bl_x = {{(2*WIDTH-H){1'b0}}, r_mb[H-1:0]};
    assign w_bh_x = {{(WIDTH-1+H){r_mb[WIDTH]}}, r_mb[WIDTH:H]};
    assign w_prod = r_pl + (r_ph << H);

    assign w_up      = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff    = w_up - {1'b0, r_dvs};
    assign w_ge      = ~w_diff[WIDTH];
    assign w_acc_nxt = w_ge ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                            : {r_acc[2*WIDTH-2:0], 1'b0};
    assign w_quo     = r_acc[WIDTH-1:0];
    assign w_rem     = r_acc[2*WIDTH-1:WIDTH];

    assign isbusy  = (r_state != S_IDLE) | (w_take & (w_op_mul | w_op_div));
    assign MD_Done = ((r_state == S_MUL1) | (r_state == S_FIX)) & ~MD_Cancel;
    assign HI      = r_hi;
    assign LO      = r_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_pl    <= '0;
            r_ph    <= '0;
            r_acc   <= '0;
            r_dvs   <= '0;
            r_sq    <= 1'b0;
            r_sr    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        case (EX_MDOp)
                            OP_MULT, OP_MULTU: begin
                                r_ma    <= {w_sgn_m & EX_A[WIDTH-1], EX_A};
                                r_mb    <= {w_sgn_m & EX_B[WIDTH-1], EX_B};
                                r_state <= S_MUL0;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                                r_dvs   <= w_b_mag;
                                r_sq    <= w_sgn_d & ~w_bz
                                           & (EX_A[WIDTH-1] ^ EX_B[WIDTH-1]);
                                r_sr    <= w_a_neg;
                                r_cnt   <= '0;
                                r_state <= S_DIV;
                            end
                            OP_MTHI: r_hi <= EX_A;
                            OP_MTLO: r_lo <= EX_A;
                            default: ;
                        endcase
                    end
                end
                S_MUL0: begin
                    if (MD_Cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_pl    <= w_ma_x * w_bl_x;
                        r_ph    <= w_ma_x * w_bh_x;
                        r_state <= S_MUL1;
                    end
                end
                S_MUL1: begin
                    if (!MD_Cancel) begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_state <= S_IDLE;
                end
                S_DIV: begin
                    if (MD_Cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (!MD_Cancel) begin
                        r_lo <= r_sq ? -w_quo : w_quo;
                        r_hi <= r_sr ? -w_rem : w_rem;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Bench for hilo_md_ctrl: cycle-level countdown model with arithmetic
// results, per-cycle compare, plus literal checks of the directed cases.
module tb_hilo_md_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        EX_MDValid;
    logic [2:0]  EX_MDOp;
    logic [31:0] EX_A;
    logic [31:0] EX_B;
    logic        EX_Adv;
    logic        MD_Cancel;
    logic        isbusy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        MD_Done;

    int total = 0;
    int bad   = 0;

    hilo_md_ctrl #(.WIDTH(32), .DIV_ITERS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .EX_MDValid (EX_MDValid),
        .EX_MDOp    (EX_MDOp),
        .EX_A       (EX_A),
        .EX_B       (EX_B),
        .EX_Adv     (EX_Adv),
        .MD_Cancel  (MD_Cancel),
        .isbusy     (isbusy),
        .HI         (HI),
        .LO         (LO),
        .MD_Done    (MD_Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] f_mul(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        if (op == 3'd1) return 64'(sa * sb);
        return ua * ub;
    endfunction

    // Returns {HI, LO} = {remainder, quotient}
    function automatic logic [63:0] f_div(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int sa;
        int sb;
        int q;
        int r;
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (op == 3'd4) return {a % b, a / b};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF)
            return {32'h0, 32'h80000000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {32'(r), 32'(q)};
    endfunction

    // Model: m_left = busy cycles still to come; results land when it hits 1.
    int          m_left = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        m_take;

    assign m_take = EX_MDValid && EX_Adv && !MD_Cancel && (m_left == 0);

    always @(posedge clk) begin
        if (rst) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else if (m_left > 0) begin
            if (MD_Cancel) begin
                m_left <= 0;
            end else if (m_left == 1) begin
                m_hi   <= p_hi;
                m_lo   <= p_lo;
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (m_take) begin
            case (EX_MDOp)
                3'd1, 3'd2: begin
                    {p_hi, p_lo} <= f_mul(EX_MDOp, EX_A, EX_B);
                    m_left       <= 2;
                end
                3'd3, 3'd4: begin
                    {p_hi, p_lo} <= f_div(EX_MDOp, EX_A, EX_B);
                    m_left       <= 33;
                end
                3'd5: m_hi <= EX_A;
                3'd6: m_lo <= EX_A;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_busy", 64'(isbusy),
                64'((m_left != 0) ||
                    (m_take && EX_MDOp >= 3'd1 && EX_MDOp <= 3'd4)));
            chk("cyc_done", 64'(MD_Done),
                64'((m_left == 1) && !MD_Cancel));
            chk("cyc_hi", 64'(HI), 64'(m_hi));
            chk("cyc_lo", 64'(LO), 64'(m_lo));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int nb, output int nd);
        nb = 0;
        nd = 0;
        step();
        EX_MDValid = 1'b1;
        EX_MDOp    = op;
        EX_A       = a;
        EX_B       = b;
        EX_Adv     = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (MD_Done) nd++;
            if (!isbusy) break;
            nb++;
            step();
            EX_MDValid = 1'b0;
        end
        step();
        EX_MDValid = 1'b0;
    endtask

    int nb;
    int nd;
    int n;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        EX_MDValid = 1'b0;
        EX_MDOp    = 3'd0;
        EX_A       = '0;
        EX_B       = '0;
        EX_Adv     = 1'b0;
        MD_Cancel  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hi", 64'(HI), 64'h0);
        chk("rst_lo", 64'(LO), 64'h0);
        chk("rst_busy", 64'(isbusy), 64'h0);

        run(3'd1, 32'hFFFFFFFE, 32'd3, nb, nd);
        chk("mult_busy", 64'(nb), 64'd3);
        chk("mult_done", 64'(nd), 64'd1);
        chk("mult_hi", 64'(HI), 64'hFFFFFFFF);
        chk("mult_lo", 64'(LO), 64'hFFFFFFFA);

        run(3'd2, 32'hFFFFFFFE, 32'd3, nb, nd);
        chk("multu_hi", 64'(HI), 64'h00000002);
        chk("multu_lo", 64'(LO), 64'hFFFFFFFA);

        run(3'd3, 32'hFFFFFFF9, 32'd2, nb, nd);
        chk("div_busy", 64'(nb), 64'd34);
        chk("div_done", 64'(nd), 64'd1);
        chk("div_lo", 64'(LO), 64'hFFFFFFFD);
        chk("div_hi", 64'(HI), 64'hFFFFFFFF);

        run(3'd4, 32'd100, 32'd7, nb, nd);
        chk("divu_lo", 64'(LO), 64'd14);
        chk("divu_hi", 64'(HI), 64'd2);

        run(3'd3, 32'd7, 32'hFFFFFFFE, nb, nd);
        chk("div_negb_lo", 64'(LO), 64'hFFFFFFFD);
        chk("div_negb_hi", 64'(HI), 64'h00000001);

        run(3'd4, 32'h12345678, 32'h0, nb, nd);
        chk("dz_busy", 64'(nb), 64'd34);
        chk("dz_hi", 64'(HI), 64'h12345678);
        chk("dz_lo", 64'(LO), 64'hFFFFFFFF);

        run(3'd3, 32'h80000000, 32'hFFFFFFFF, nb, nd);
        chk("ovf_lo", 64'(LO), 64'h80000000);
        chk("ovf_hi", 64'(HI), 64'h0);

        run(3'd5, 32'hA5A5A5A5, 32'h0, nb, nd);
        chk("mthi_busy", 64'(nb), 64'd0);
        chk("mthi_done", 64'(nd), 64'd0);
        chk("mthi_hi", 64'(HI), 64'hA5A5A5A5);

        step();
        EX_MDValid = 1'b1;
        EX_MDOp    = 3'd1;
        EX_A       = 32'd9;
        EX_B       = 32'd9;
        EX_Adv     = 1'b0;
        @(negedge clk);
        chk("noadv_busy", 64'(isbusy), 64'h0);
        step();
        EX_MDValid = 1'b0;
        repeat (4) step();
        chk("noadv_hi", 64'(HI), 64'hA5A5A5A5);
        chk("noadv_lo", 64'(LO), 64'h80000000);

        EX_MDValid = 1'b1;
        EX_MDOp    = 3'd3;
        EX_A       = 32'hFFFFFFF9;
        EX_B       = 32'd2;
        EX_Adv     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            EX_MDValid = 1'b0;
        end
        MD_Cancel = 1'b1;
        step();
        MD_Cancel = 1'b0;
        @(negedge clk);
        chk("cdiv_busy", 64'(isbusy), 64'h0);
        repeat (40) step();
        chk("cdiv_hi", 64'(HI), 64'hA5A5A5A5);
        chk("cdiv_lo", 64'(LO), 64'h80000000);

        EX_MDValid = 1'b1;
        EX_MDOp    = 3'd1;
        EX_A       = 32'd5;
        EX_B       = 32'd5;
        step();
        EX_MDValid = 1'b0;
        step();
        MD_Cancel = 1'b1;
        @(negedge clk);
        chk("cmul_done", 64'(MD_Done), 64'h0);
        step();
        MD_Cancel = 1'b0;
        @(negedge clk);
        chk("cmul_busy", 64'(isbusy), 64'h0);
        chk("cmul_hi", 64'(HI), 64'hA5A5A5A5);
        chk("cmul_lo", 64'(LO), 64'h80000000);

        step();
        EX_MDValid = 1'b1;
        EX_MDOp    = 3'd4;
        EX_A       = 32'd100;
        EX_B       = 32'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            EX_MDValid = 1'b0;
        end
        EX_MDValid = 1'b1;
        EX_MDOp    = 3'd6;
        EX_A       = 32'hDEADBEEF;
        step();
        EX_MDValid = 1'b0;
        n = 0;
        @(negedge clk);
        while (isbusy && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("mtlo_wait", 64'(n < 60), 64'h1);
        chk("mtlo_lo", 64'(LO), 64'd14);
        chk("mtlo_hi", 64'(HI), 64'd2);

        step();
        EX_MDValid = 1'b1;
        EX_MDOp    = 3'd3;
        EX_A       = 32'hFFFFFFF9;
        EX_B       = 32'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            EX_MDValid = 1'b0;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rmid_busy", 64'(isbusy), 64'h0);
        chk("rmid_hi", 64'(HI), 64'h0);
        chk("rmid_lo", 64'(LO), 64'h0);

        run(3'd1, 32'd6, 32'd7, nb, nd);
        chk("post_lo", 64'(LO), 64'd42);
        chk("post_hi", 64'(HI), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
